// File: rtl/cam_line_pkt_sched_pkg.sv
// Shared types and helpers for the camera line packet scheduler.
package cam_pkt_pkg;

  localparam int FID_W      = 8;
  localparam int LINE_IDX_W = 16;

  typedef enum logic [1:0] {
    WR_WAIT_VS,
    WR_WAIT_LINE,
    WR_LINE
  } wr_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_SEND,
    TX_DONE
  } tx_state_t;

  function automatic logic [15:0] line_bytes(input int unsigned pix, input int unsigned dw);
    return 16'(pix * (dw / 8));
  endfunction

endpackage

// File: rtl/cam_line_pkt_sched_ram.sv
// Ping-pong line storage: two banks selected by the address MSB, registered read port.
module line_bank_ram #(
  parameter int LINE_PIX = 640,
  parameter int DW       = 16,
  parameter int AW       = $clog2(LINE_PIX) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset so the packer sees zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cam_line_pkt_sched.sv
// Buffers camera lines in a ping-pong RAM and hands complete lines to the UDP packer.
module cam_line_pkt_sched #(
  parameter int LINE_PIX    = 640,
  parameter int FRAME_LINES = 480,
  parameter int DW          = 16,
  parameter int FID_W       = cam_pkt_pkg::FID_W
) (
  input  logic             i_pclk,
  input  logic             rst,
  input  logic             i_vsync,
  input  logic             i_href,
  input  logic             i_pix_vld,
  input  logic [DW-1:0]    i_pix_data,
  output logic             o_tx_req,
  input  logic             i_tx_ack,
  output logic [FID_W-1:0] o_tx_frame,
  output logic [15:0]      o_tx_line,
  output logic [15:0]      o_tx_len,
  input  logic             i_tx_rd,
  output logic [DW-1:0]    o_tx_data,
  output logic             o_tx_done,
  output logic [15:0]      o_drop_cnt,
  output logic             o_err_short
);
  import cam_pkt_pkg::*;

  localparam int PIX_AW = $clog2(LINE_PIX);
  localparam int CNT_W  = $clog2(LINE_PIX + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(LINE_PIX);
  localparam logic [PIX_AW-1:0] LAST_RD  = PIX_AW'(LINE_PIX - 1);

  logic                  r_vs_d, r_href_d;
  wr_state_t             r_wr_state;
  tx_state_t             r_tx_state;
  logic [FID_W-1:0]      r_fid;
  logic [LINE_IDX_W-1:0] r_line_idx;
  logic                  r_wr_bank;
  logic [CNT_W-1:0]      r_pix_cnt;
  logic                  r_long;
  logic [1:0]            r_ready;
  logic [1:0]            r_wr_own;
  logic [FID_W-1:0]      r_tag_fid  [2];
  logic [LINE_IDX_W-1:0] r_tag_line [2];
  logic                  r_rd_bank;
  logic [PIX_AW-1:0]     r_rd_cnt;

  logic       w_vs_edge, w_href_rise, w_href_fall;
  logic [1:0] w_free;
  logic       w_tx_free, w_line_ok, w_in_range, w_mark, w_tx_take;
  logic       w_wr_en, w_rd_en;

  assign w_vs_edge   = i_vsync & ~r_vs_d;
  assign w_href_rise = i_href & ~r_href_d;
  assign w_href_fall = ~i_href & r_href_d;

  // A bank being released by the tx side this cycle already counts as free.
  assign w_tx_free = (r_tx_state == TX_DONE);
  assign w_free[0] = ~r_wr_own[0] & (~r_ready[0] | (w_tx_free & ~r_rd_bank));
  assign w_free[1] = ~r_wr_own[1] & (~r_ready[1] | (w_tx_free &  r_rd_bank));

  assign w_line_ok  = (r_pix_cnt == FULL_CNT) & ~r_long;
  assign w_in_range = (r_line_idx < LINE_IDX_W'(FRAME_LINES));
  assign w_mark     = (r_wr_state == WR_LINE) & w_href_fall & ~w_vs_edge & w_line_ok;
  // Take a line being marked this cycle directly so the request is not delayed.
  assign w_tx_take  = (r_tx_state == TX_IDLE) &
                      (r_ready[r_rd_bank] | (w_mark & (r_wr_bank == r_rd_bank)));

  assign w_wr_en = (r_wr_state == WR_LINE) & i_href & i_pix_vld & ~w_vs_edge &
                   (r_pix_cnt < FULL_CNT);
  assign w_rd_en = (r_tx_state == TX_SEND) & i_tx_rd;

  assign o_tx_len = line_bytes(LINE_PIX, DW);

  line_bank_ram #(
    .LINE_PIX (LINE_PIX),
    .DW       (DW),
    .AW       (PIX_AW + 1)
  ) u_ram (
    .i_clk   (i_pclk),
    .i_rst   (rst),
    .i_we    (w_wr_en),
    .i_waddr ({r_wr_bank, r_pix_cnt[PIX_AW-1:0]}),
    .i_wdata (i_pix_data),
    .i_re    (w_rd_en),
    .i_raddr ({r_rd_bank, r_rd_cnt}),
    .o_rdata (o_tx_data)
  );

  always_ff @(posedge i_pclk) begin
    if (rst) begin
      r_vs_d        <= 1'b0;
      r_href_d      <= 1'b0;
      r_wr_state    <= WR_WAIT_VS;
      r_fid         <= '0;
      r_line_idx    <= '0;
      r_wr_bank     <= 1'b0;
      r_pix_cnt     <= '0;
      r_long        <= 1'b0;
      r_ready       <= '0;
      r_wr_own      <= '0;
      r_tag_fid[0]  <= '0;
      r_tag_fid[1]  <= '0;
      r_tag_line[0] <= '0;
      r_tag_line[1] <= '0;
      o_drop_cnt    <= '0;
      o_err_short   <= 1'b0;
    end else begin
      r_vs_d      <= i_vsync;
      r_href_d    <= i_href;
      o_err_short <= 1'b0;
      if (w_tx_free) r_ready[r_rd_bank] <= 1'b0;

      if (w_vs_edge) begin
        r_fid      <= r_fid + FID_W'(1);
        r_line_idx <= '0;
        if (r_wr_state == WR_LINE) r_wr_own[r_wr_bank] <= 1'b0;
        r_wr_state <= WR_WAIT_LINE;
      end else begin
        case (r_wr_state)
          WR_WAIT_VS: ;
          WR_WAIT_LINE: begin
            if (w_href_rise && w_in_range) begin
              if (w_free[r_wr_bank]) begin
                r_wr_own[r_wr_bank] <= 1'b1;
                r_pix_cnt           <= '0;
                r_long              <= 1'b0;
                r_wr_state          <= WR_LINE;
              end else begin
                if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
                r_line_idx <= r_line_idx + LINE_IDX_W'(1);
              end
            end
          end
          WR_LINE: begin
            if (i_href && i_pix_vld) begin
              if (r_pix_cnt < FULL_CNT) r_pix_cnt <= r_pix_cnt + CNT_W'(1);
              else                      r_long    <= 1'b1;
            end
            if (w_href_fall) begin
              r_wr_own[r_wr_bank] <= 1'b0;
              r_line_idx          <= r_line_idx + LINE_IDX_W'(1);
              r_wr_state          <= WR_WAIT_LINE;
              if (w_line_ok) begin
                r_ready[r_wr_bank]    <= 1'b1;
                r_tag_fid[r_wr_bank]  <= r_fid;
                r_tag_line[r_wr_bank] <= r_line_idx;
                r_wr_bank             <= ~r_wr_bank;
              end else begin
                o_err_short <= 1'b1;
              end
            end
          end
          default: r_wr_state <= WR_WAIT_VS;
        endcase
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      o_tx_req   <= 1'b0;
      o_tx_frame <= '0;
      o_tx_line  <= '0;
      o_tx_done  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
    end else begin
      o_tx_done <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_take) begin
            o_tx_req   <= 1'b1;
            o_tx_frame <= r_ready[r_rd_bank] ? r_tag_fid[r_rd_bank]  : r_fid;
            o_tx_line  <= r_ready[r_rd_bank] ? r_tag_line[r_rd_bank] : r_line_idx;
            r_rd_cnt   <= '0;
            r_tx_state <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (i_tx_ack) begin
            o_tx_req   <= 1'b0;
            r_tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (i_tx_rd) begin
            r_rd_cnt <= r_rd_cnt + PIX_AW'(1);
            if (r_rd_cnt == LAST_RD) begin
              o_tx_done  <= 1'b1;
              r_tx_state <= TX_DONE;
            end
          end
        end
        TX_DONE: begin
          r_rd_bank  <= ~r_rd_bank;
          r_tx_state <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_line_pkt_sched.sv
// Self-checking bench for cam_line_pkt_sched with a small line/frame reference model.
module tb_cam_line_pkt_sched;

  localparam int LP = 4;
  localparam int FL = 3;
  localparam int DW = 16;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst, i_vsync, i_href, i_pix_vld, i_tx_ack, i_tx_rd;
  logic [DW-1:0] i_pix_data;
  logic          o_tx_req, o_tx_done, o_err_short;
  logic [FW-1:0] o_tx_frame;
  logic [15:0]   o_tx_line, o_tx_len, o_drop_cnt;
  logic [DW-1:0] o_tx_data;

  always #5 clk = ~clk;

  cam_line_pkt_sched #(
    .LINE_PIX    (LP),
    .FRAME_LINES (FL),
    .DW          (DW),
    .FID_W       (FW)
  ) dut (
    .i_pclk      (clk),
    .rst         (rst),
    .i_vsync     (i_vsync),
    .i_href      (i_href),
    .i_pix_vld   (i_pix_vld),
    .i_pix_data  (i_pix_data),
    .o_tx_req    (o_tx_req),
    .i_tx_ack    (i_tx_ack),
    .o_tx_frame  (o_tx_frame),
    .o_tx_line   (o_tx_line),
    .o_tx_len    (o_tx_len),
    .i_tx_rd     (i_tx_rd),
    .o_tx_data   (o_tx_data),
    .o_tx_done   (o_tx_done),
    .o_drop_cnt  (o_drop_cnt),
    .o_err_short (o_err_short)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: frame id, line index within frame, seen a vsync yet.
  int unsigned m_fid, m_idx;
  bit          m_in_frame;

  logic [15:0] lbuf [8];

  typedef struct {
    bit          vs;
    int          npix;
    logic [15:0] base;
    bit          err;
    bit          req;
    int          frame;
    int          line;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_vs();
    m_fid      = (m_fid + 1) % 256;
    m_idx      = 0;
    m_in_frame = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_vsync = 1'b0; i_href = 1'b0; i_pix_vld = 1'b0;
    i_pix_data = '0; i_tx_ack = 1'b0; i_tx_rd = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_fid = 0; m_idx = 0; m_in_frame = 1'b0;
  endtask

  task automatic do_vsync();
    i_vsync = 1'b1; tick();
    i_vsync = 1'b0; tick();
    model_vs();
  endtask

  task automatic fill_line(input logic [15:0] base);
    for (int k = 0; k < 8; k++) lbuf[k] = base + 16'(k);
  endtask

  task automatic send_line(input int npix);
    i_href = 1'b1; tick();
    for (int k = 0; k < npix; k++) begin
      i_pix_vld = 1'b1; i_pix_data = lbuf[k]; tick();
    end
    i_pix_vld = 1'b0;
    i_href = 1'b0; tick();
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!o_tx_req && n < budget) begin
      tick();
      n++;
    end
    chk("req_wait", o_tx_req, 1);
  endtask

  // gap < 0 picks a random 0..2 idle cycles between reads.
  // vsmode 1: one vsync pulse after the 2nd read; 2: random vsync pulses in gaps.
  task automatic serve(input int fr, input int ln, input int gap, input int vsmode);
    chk("req_up", o_tx_req, 1);
    chk("tag_frame", o_tx_frame, fr);
    chk("tag_line", o_tx_line, ln);
    chk("tx_len", o_tx_len, 2 * LP);
    i_tx_ack = 1'b1; tick(); i_tx_ack = 1'b0;
    chk("req_after_ack", o_tx_req, 0);
    for (int i = 0; i < LP; i++) begin
      i_tx_rd = 1'b1; tick(); i_tx_rd = 1'b0;
      chk("rd_data", o_tx_data, lbuf[i]);
      chk("done_pulse", o_tx_done, (i == LP - 1));
      if (i < LP - 1) begin
        int ng;
        ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int g = 0; g < ng; g++) begin
          bit vs;
          vs = (g == 0) && ((vsmode == 1 && i == 1) || (vsmode == 2 && $urandom_range(0, 3) == 0));
          i_vsync = vs; tick(); i_vsync = 1'b0;
          if (vs) model_vs();
        end
      end
    end
    tick();
    chk("done_clear", o_tx_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_req", o_tx_req, 0);
    chk("rst_frame", o_tx_frame, 0);
    chk("rst_line", o_tx_line, 0);
    chk("rst_data", o_tx_data, 0);
    chk("rst_done", o_tx_done, 0);
    chk("rst_drop", o_drop_cnt, 0);
    chk("rst_err", o_err_short, 0);
    chk("rst_len", o_tx_len, 8);

    // vs, npix, base, err, req, frame, line
    tbl[0] = '{1'b1, 4, 16'h0001, 1'b0, 1'b1, 1, 0};
    tbl[1] = '{1'b0, 3, 16'h0010, 1'b1, 1'b0, 0, 0};
    tbl[2] = '{1'b0, 4, 16'h0020, 1'b0, 1'b1, 1, 2};
    tbl[3] = '{1'b0, 4, 16'h0030, 1'b0, 1'b0, 0, 0};
    tbl[4] = '{1'b1, 5, 16'h0040, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{1'b0, 4, 16'h0050, 1'b0, 1'b1, 2, 1};
    tbl[6] = '{1'b0, 0, 16'h0000, 1'b1, 1'b0, 0, 0};
    tbl[7] = '{1'b1, 4, 16'h0070, 1'b0, 1'b1, 3, 0};
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].vs) do_vsync();
      fill_line(tbl[t].base);
      send_line(tbl[t].npix);
      chk("tbl_err", o_err_short, tbl[t].err);
      chk("tbl_req", o_tx_req, tbl[t].req);
      if (tbl[t].req) serve(tbl[t].frame, tbl[t].line, 0, 0);
      else begin
        tick();
        chk("tbl_err_clear", o_err_short, 0);
        chk("tbl_no_req", o_tx_req, 0);
      end
    end

    // Backpressure: two lines buffered, third dropped, then drained in order.
    do_vsync();
    fill_line(16'h0100); send_line(LP);
    chk("bp_req0", o_tx_req, 1);
    fill_line(16'h0200); send_line(LP);
    chk("bp_err1", o_err_short, 0);
    fill_line(16'h0300); send_line(LP);
    chk("bp_drop", o_drop_cnt, 1);
    chk("bp_err2", o_err_short, 0);
    chk("bp_req_hold", o_tx_req, 1);
    fill_line(16'h0100);
    serve(4, 0, 0, 0);
    wait_req(10);
    fill_line(16'h0200);
    serve(4, 1, 0, 0);
    chk("bp_drop_after", o_drop_cnt, 1);

    // Reset in the middle of a send.
    do_vsync();
    fill_line(16'h0400); send_line(LP);
    chk("mid_req", o_tx_req, 1);
    i_tx_ack = 1'b1; tick(); i_tx_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_tx_rd = 1'b1; tick(); i_tx_rd = 1'b0;
    end
    chk("mid_data1", o_tx_data, 16'h0401);
    rst = 1'b1; tick(); rst = 1'b0;
    m_fid = 0; m_idx = 0; m_in_frame = 1'b0;
    chk("mrst_req", o_tx_req, 0);
    chk("mrst_frame", o_tx_frame, 0);
    chk("mrst_line", o_tx_line, 0);
    chk("mrst_data", o_tx_data, 0);
    chk("mrst_done", o_tx_done, 0);
    chk("mrst_drop", o_drop_cnt, 0);
    chk("mrst_err", o_err_short, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_done", o_tx_done, 0);
    end
    do_vsync();
    fill_line(16'h0500); send_line(LP);
    serve(1, 0, 0, 0);

    // Gapped reads with a vsync in the middle of the send.
    fill_line(16'h0600); send_line(LP);
    serve(1, 1, 2, 1);
    fill_line(16'h0700); send_line(LP);
    serve(2, 0, 0, 0);

    // Randomised lines against the reference model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int  npix, r, efr, eln;
      bit  ereq, eerr;
      if ($urandom_range(0, 4) == 0) do_vsync();
      r = int'($urandom_range(0, 5));
      npix = (r < 3) ? LP : (r == 3) ? LP - 1 : (r == 4) ? LP + 1 : int'($urandom_range(0, 2));
      for (int k = 0; k < 8; k++) lbuf[k] = 16'($urandom);
      ereq = 1'b0; eerr = 1'b0; efr = 0; eln = 0;
      if (m_in_frame && m_idx < FL) begin
        if (npix == LP) begin
          ereq = 1'b1; efr = int'(m_fid); eln = int'(m_idx);
        end else begin
          eerr = 1'b1;
        end
        m_idx++;
      end
      send_line(npix);
      chk("rnd_err", o_err_short, eerr);
      chk("rnd_req", o_tx_req, ereq);
      if (ereq) serve(efr, eln, -1, 2);
    end
    chk("rnd_drop", o_drop_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
